sevenseg_scan: RTL and testbench

Time-multiplexed display scanner that sits directly upstream of the 4-bit-to-7-segment decoder. It holds a multi-digit hex value, steps through the digits at a fixed refresh rate, and drives one nibble at a time into the decoder's 4-bit input. It also drives a one-hot digit enable for the display commons. It optionally blanks leading zeros and swaps in new values only at frame boundaries, so the display never tears.

---
 rtl/sevenseg_scan_pkg.sv | 17 +
 rtl/sevenseg_scan_if.sv | 23 ++
 rtl/sevenseg_scan_tick_gen.sv | 33 +++
 rtl/sevenseg_scan.sv | 114 +++++++++++
 tb/tb_sevenseg_scan.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/sevenseg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Also holds the index-width rule used by the digit counter.
package sevenseg_scan_pkg;

  localparam logic [3:0] BLANK_CODE          = 4'hF;
  localparam int         DEFAULT_REFRESH_DIV = 50000;

  // Digit index width: max(1, clog2(digits)).
  function automatic int idx_width(input int digits);
    if (digits > 1) begin
      return $clog2(digits);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// Host-side value/strobe inputs and decoder/common-driver outputs of the scanner.
interface sevenseg_scan_if #(
  parameter int DIGITS = 4
);

  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  blank_lz;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     dig_en;
  logic                  frame_start;

  modport master (
    output load, value, blank_lz,
    input  nib, dig_en, frame_start
  );

  modport slave (
    input  load, value, blank_lz,
    output nib, dig_en, frame_start
  );

endinterface

// File: rtl/sevenseg_scan_tick_gen.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and flags the last count as the slot tick.
module scan_tick_gen #(
  parameter int REFRESH_DIV = sevenseg_scan_pkg::DEFAULT_REFRESH_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick = (cnt_q == LAST);
    if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed hex display scanner: steps one digit per refresh slot, swaps the
// displayed value only at frame boundaries and optionally blanks leading zeros.
module sevenseg_scan #(
  parameter int         DIGITS      = 4,
  parameter int         REFRESH_DIV = sevenseg_scan_pkg::DEFAULT_REFRESH_DIV,
  parameter logic [3:0] BLANK_CODE  = sevenseg_scan_pkg::BLANK_CODE
) (
  input  logic            clk,
  input  logic            rst,
  sevenseg_scan_if.slave  bus
);

  import sevenseg_scan_pkg::*;

  localparam int               IDX_W    = idx_width(DIGITS);
  localparam int               VAL_W    = 4 * DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic              tick_s;
  logic [IDX_W-1:0]  sel_s;
  logic              frame_s;
  logic [DIGITS-1:0] blank_s;
  logic              zero_above_s;
  logic [3:0]        sel_nib_s;
  logic              sel_blank_s;

  logic [IDX_W-1:0]  idx_q,         idx_d;
  logic [VAL_W-1:0]  shadow_q,      shadow_d;
  logic [VAL_W-1:0]  active_q,      active_d;
  logic [3:0]        nib_q,         nib_d;
  logic [DIGITS-1:0] dig_en_q,      dig_en_d;
  logic              frame_start_q, frame_start_d;

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // An all-zero dig_en means no tick has happened since reset, so scanning starts at digit 0.
  always_comb begin
    if ((dig_en_q == '0) || (idx_q == LAST_IDX)) begin
      sel_s = '0;
    end else begin
      sel_s = idx_q + IDX_W'(1);
    end
    frame_s  = tick_s & (sel_s == '0);
    shadow_d = bus.load ? bus.value : shadow_q;
    if (frame_s) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end
  end

  // Leading-zero mask from the most significant digit down; digit 0 always shows.
  always_comb begin
    blank_s      = '0;
    zero_above_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s & (active_d[4*i +: 4] == 4'h0);
      blank_s[i]   = bus.blank_lz & zero_above_s & (i != 0);
    end
  end

  always_comb begin
    sel_nib_s   = 4'h0;
    sel_blank_s = 1'b0;
    dig_en_d    = dig_en_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_s == IDX_W'(i)) begin
        sel_nib_s   = active_d[4*i +: 4];
        sel_blank_s = blank_s[i];
      end
    end
    if (tick_s) begin
      idx_d         = sel_s;
      nib_d         = sel_blank_s ? BLANK_CODE : sel_nib_s;
      frame_start_d = frame_s;
      for (int i = 0; i < DIGITS; i++) begin
        dig_en_d[i] = (sel_s == IDX_W'(i));
      end
    end else begin
      idx_d         = idx_q;
      nib_d         = nib_q;
      frame_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      nib_q         <= BLANK_CODE;
      dig_en_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      nib_q         <= nib_d;
      dig_en_q      <= dig_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.nib         = nib_q;
  assign bus.dig_en      = dig_en_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with DIGITS=4, REFRESH_DIV=4 (one digit slot every 4 clocks).
module tb_sevenseg_scan;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sevenseg_scan_if #(.DIGITS(4)) bus ();

  sevenseg_scan #(
    .DIGITS      (4),
    .REFRESH_DIV (4),
    .BLANK_CODE  (4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called one cycle after a frame-boundary tick; checks all four slots of that frame.
  task automatic check_frame(input string tag, input logic [15:0] exp);
    chk({tag, " fs"}, 32'(bus.frame_start), 32'd1);
    for (int j = 0; j < 4; j++) begin
      if (j != 0) begin
        cyc(4);
      end
      chk($sformatf("%s dig_en%0d", tag, j), 32'(bus.dig_en), 32'(4'b0001 << j));
      chk($sformatf("%s nib%0d", tag, j), 32'(bus.nib), 32'(exp[4*j +: 4]));
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.blank_lz = 1'b0;
    cyc(2);
    chk("rst dig_en", 32'(bus.dig_en), 32'd0);
    chk("rst nib", 32'(bus.nib), 32'hF);
    chk("rst fs", 32'(bus.frame_start), 32'd0);
    rst = 1'b0;

    // 1: first tick lands on the 4th edge after reset release
    cyc(1);
    chk("pre dig_en e1", 32'(bus.dig_en), 32'd0);
    chk("pre nib e1", 32'(bus.nib), 32'hF);
    cyc(2);
    chk("pre dig_en e3", 32'(bus.dig_en), 32'd0);
    cyc(1);
    chk("first dig_en", 32'(bus.dig_en), 32'b0001);
    chk("first nib", 32'(bus.nib), 32'h0);
    chk("first fs", 32'(bus.frame_start), 32'd1);
    cyc(1);
    chk("fs one cycle", 32'(bus.frame_start), 32'd0);
    chk("hold dig_en", 32'(bus.dig_en), 32'b0001);
    cyc(3);
    chk("step dig_en 1", 32'(bus.dig_en), 32'b0010);
    cyc(4);
    chk("step dig_en 2", 32'(bus.dig_en), 32'b0100);
    cyc(4);
    chk("step dig_en 3", 32'(bus.dig_en), 32'b1000);
    cyc(4);
    chk("wrap dig_en", 32'(bus.dig_en), 32'b0001);
    chk("wrap fs", 32'(bus.frame_start), 32'd1);

    // 2: mid-frame load waits for the next frame
    cyc(1);
    bus.load  = 1'b1;
    bus.value = 16'h1234;
    cyc(1);
    bus.load = 1'b0;
    chk("midload nib0", 32'(bus.nib), 32'h0);
    cyc(2);
    chk("midload nib1", 32'(bus.nib), 32'h0);
    cyc(8);
    chk("midload nib3", 32'(bus.nib), 32'h0);
    cyc(4);
    check_frame("v1234", 16'h1234);

    // 3: leading-zero blanking on and off, and the all-zero value
    bus.load     = 1'b1;
    bus.value    = 16'h00A0;
    bus.blank_lz = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    cyc(3);
    check_frame("lz00A0", 16'hFFA0);
    bus.blank_lz = 1'b0;
    cyc(4);
    check_frame("nolz00A0", 16'h00A0);
    bus.load     = 1'b1;
    bus.value    = 16'h0000;
    bus.blank_lz = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    cyc(3);
    check_frame("lz0000", 16'hFFF0);

    // 4: load coincident with the frame-boundary tick shows immediately
    cyc(3);
    bus.load     = 1'b1;
    bus.value    = 16'hBEEF;
    bus.blank_lz = 1'b0;
    cyc(1);
    bus.load = 1'b0;
    check_frame("bypass", 16'hBEEF);
    cyc(4);
    chk("bypass shadow nib", 32'(bus.nib), 32'hF);
    chk("bypass shadow fs", 32'(bus.frame_start), 32'd1);

    // 5: two loads in one frame, the last one wins
    bus.load  = 1'b1;
    bus.value = 16'h1111;
    cyc(1);
    bus.load = 1'b0;
    cyc(2);
    bus.load  = 1'b1;
    bus.value = 16'h2222;
    cyc(1);
    bus.load = 1'b0;
    chk("dbl old nib1", 32'(bus.nib), 32'hE);
    cyc(8);
    chk("dbl old nib3", 32'(bus.nib), 32'hB);
    cyc(4);
    check_frame("dbl", 16'h2222);

    // 6: reset while digit 2 is active with a load pending
    cyc(12);
    bus.load  = 1'b1;
    bus.value = 16'h9999;
    cyc(1);
    bus.load = 1'b0;
    chk("pre-rst dig_en", 32'(bus.dig_en), 32'b0100);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst dig_en", 32'(bus.dig_en), 32'd0);
    chk("midrst nib", 32'(bus.nib), 32'hF);
    chk("midrst fs", 32'(bus.frame_start), 32'd0);
    cyc(3);
    chk("midrst wait dig_en", 32'(bus.dig_en), 32'd0);
    cyc(1);
    check_frame("postrst", 16'h0000);
    cyc(4);
    chk("postrst2 nib0", 32'(bus.nib), 32'h0);
    chk("postrst2 dig_en", 32'(bus.dig_en), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
